// File: rtl/mdu_pkg.sv
// Shared definitions for the multiply/divide unit: op codes, FSM states, payloads.
package mdu_pkg;

  localparam int unsigned DATA_W         = 32;
  localparam int unsigned OP_W           = 4;
  localparam int unsigned MUL_CYCLES_DEF = 5;
  localparam int unsigned DIV_CYCLES_DEF = 10;

  // Op encodings shared with the pipeline control unit.
  typedef enum logic [OP_W-1:0] {
    OP_NONE  = 4'd0,
    OP_MULT  = 4'd1,
    OP_MULTU = 4'd2,
    OP_DIV   = 4'd3,
    OP_DIVU  = 4'd4,
    OP_MFHI  = 4'd5,
    OP_MFLO  = 4'd6,
    OP_MTHI  = 4'd7,
    OP_MTLO  = 4'd8
  } op_e;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_RUN  = 1'b1
  } state_e;

  // HI/LO pair; hi occupies the upper half so a 64-bit product maps directly.
  typedef struct packed {
    logic [DATA_W-1:0] hi;
    logic [DATA_W-1:0] lo;
  } hilo_t;

  // True for the four ops that occupy the unit for several cycles.
  function automatic logic is_launch_op(input logic [OP_W-1:0] op);
    return (op == OP_MULT) || (op == OP_MULTU) || (op == OP_DIV) || (op == OP_DIVU);
  endfunction

  function automatic logic is_div_op(input logic [OP_W-1:0] op);
    return (op == OP_DIV) || (op == OP_DIVU);
  endfunction

endpackage

// File: rtl/mdu_if.sv
// Pipeline-to-MDU bus: E-stage request side (master) and the unit (slave).
interface mdu_if;
  import mdu_pkg::*;

  logic              req;
  logic              start;
  logic [OP_W-1:0]   op;
  logic [DATA_W-1:0] d1;
  logic [DATA_W-1:0] d2;
  logic              busy;
  logic [DATA_W-1:0] out;
  logic [DATA_W-1:0] hi;
  logic [DATA_W-1:0] lo;

  modport master (
    output req, start, op, d1, d2,
    input  busy, out, hi, lo
  );

  modport slave (
    input  req, start, op, d1, d2,
    output busy, out, hi, lo
  );

endinterface

// File: rtl/mdu_arith.sv
// Combinational datapath: 64-bit products and quotient/remainder for the MDU.
module mdu_arith
  import mdu_pkg::*;
(
  input  logic [OP_W-1:0]   op,
  input  logic [DATA_W-1:0] a,
  input  logic [DATA_W-1:0] b,
  output hilo_t             res_c,
  output logic              keep_c
);

  logic [2*DATA_W-1:0] prod_s;
  logic [2*DATA_W-1:0] prod_u;
  logic                a_neg;
  logic                b_neg;
  logic [DATA_W-1:0]   a_mag;
  logic [DATA_W-1:0]   b_mag;
  logic [DATA_W-1:0]   b_div;
  logic [DATA_W-1:0]   q_mag;
  logic [DATA_W-1:0]   r_mag;
  logic [DATA_W-1:0]   quot;
  logic [DATA_W-1:0]   rem;

  // Products: operands widened to 64 bits so the low 64 bits are exact.
  always_comb begin
    prod_s = $signed({{DATA_W{a[DATA_W-1]}}, a}) * $signed({{DATA_W{b[DATA_W-1]}}, b});
    prod_u = {{DATA_W{1'b0}}, a} * {{DATA_W{1'b0}}, b};
  end

  // Division on magnitudes; 0x80000000 / -1 falls out as 0x80000000 rem 0 without overflow.
  always_comb begin
    a_neg = (op == OP_DIV) && a[DATA_W-1];
    b_neg = (op == OP_DIV) && b[DATA_W-1];
    a_mag = a_neg ? -a : a;
    b_mag = b_neg ? -b : b;
    b_div = (b == '0) ? DATA_W'(1) : b_mag;
    q_mag = a_mag / b_div;
    r_mag = a_mag % b_div;
    quot  = (a_neg ^ b_neg) ? -q_mag : q_mag;
    rem   = a_neg ? -r_mag : r_mag;
  end

  // Result select; keep_c tells the sequencer to leave HI/LO alone on divide-by-zero.
  always_comb begin
    res_c  = '0;
    keep_c = 1'b0;
    case (op)
      OP_MULT:  res_c = hilo_t'(prod_s);
      OP_MULTU: res_c = hilo_t'(prod_u);
      OP_DIV, OP_DIVU: begin
        res_c.hi = rem;
        res_c.lo = quot;
        keep_c   = (b == '0);
      end
      default: res_c = '0;
    endcase
  end

endmodule

// File: rtl/mdu_seq.sv
// Multi-cycle multiply/divide unit: busy sequencing, HI/LO ownership, move-to/from.
module mdu_seq
  import mdu_pkg::*;
#(
  parameter int unsigned MUL_CYCLES = MUL_CYCLES_DEF,
  parameter int unsigned DIV_CYCLES = DIV_CYCLES_DEF
) (
  input logic   clk,
  input logic   reset,
  mdu_if.slave  bus
);

  localparam int unsigned CNT_MAX = (MUL_CYCLES > DIV_CYCLES) ? MUL_CYCLES : DIV_CYCLES;
  localparam int unsigned CNT_LOG = $clog2(CNT_MAX + 1);
  localparam int unsigned CNT_W   = (CNT_LOG > 4) ? CNT_LOG : 4;

  state_e            state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [DATA_W-1:0] hi_q, hi_d;
  logic [DATA_W-1:0] lo_q, lo_d;
  logic [DATA_W-1:0] hi_tmp_q, hi_tmp_d;
  logic [DATA_W-1:0] lo_tmp_q, lo_tmp_d;
  hilo_t             res_c;
  logic              keep_c;
  logic [DATA_W-1:0] out_c;

  mdu_arith u_arith (
    .op     (bus.op),
    .a      (bus.d1),
    .b      (bus.d2),
    .res_c  (res_c),
    .keep_c (keep_c)
  );

  // State, counter and HI/LO registers; reset wins over everything.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= ST_IDLE;
      cnt_q    <= '0;
      hi_q     <= '0;
      lo_q     <= '0;
      hi_tmp_q <= '0;
      lo_tmp_q <= '0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      hi_q     <= hi_d;
      lo_q     <= lo_d;
      hi_tmp_q <= hi_tmp_d;
      lo_tmp_q <= lo_tmp_d;
    end
  end

  // Next state: launch/move only when idle and not flushed; RUN always completes.
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    hi_d     = hi_q;
    lo_d     = lo_q;
    hi_tmp_d = hi_tmp_q;
    lo_tmp_d = lo_tmp_q;
    case (state_q)
      ST_IDLE: begin
        if (!bus.req) begin
          if (bus.start && is_launch_op(bus.op)) begin
            hi_tmp_d = keep_c ? hi_q : res_c.hi;
            lo_tmp_d = keep_c ? lo_q : res_c.lo;
            cnt_d    = is_div_op(bus.op) ? CNT_W'(DIV_CYCLES) : CNT_W'(MUL_CYCLES);
            state_d  = ST_RUN;
          end else if (bus.op == OP_MTHI) begin
            hi_d = bus.d1;
          end else if (bus.op == OP_MTLO) begin
            lo_d = bus.d1;
          end
        end
      end
      ST_RUN: begin
        if (cnt_q <= CNT_W'(1)) begin
          hi_d    = hi_tmp_q;
          lo_d    = lo_tmp_q;
          cnt_d   = '0;
          state_d = ST_IDLE;
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end
    endcase
  end

  // Read port is combinational from op and the architectural registers.
  always_comb begin
    out_c = '0;
    if (bus.op == OP_MFHI) out_c = hi_q;
    else if (bus.op == OP_MFLO) out_c = lo_q;
  end

  assign bus.busy = (state_q == ST_RUN);
  assign bus.out  = out_c;
  assign bus.hi   = hi_q;
  assign bus.lo   = lo_q;

endmodule

// File: doc/mdu_seq.md
MDU_SEQ -- requirements
Module: mdu_seq

Interface
REQ-001 Parameter MUL_CYCLES, default 5, busy cycles for mult/multu.
REQ-002 Parameter DIV_CYCLES, default 10, busy cycles for div/divu.
REQ-003 clk  input  1  single clock; all state updates on rising edge.
REQ-004 reset  input  1  synchronous, active-high reset.
REQ-005 req  input  1  exception/interrupt flush; the E-stage instruction presenting start/op this cycle is being cancelled.
REQ-006 start  input  1  launch a mult/multu/div/divu this cycle.
REQ-007 op  input  4  operation code; 0 none, 1 mult, 2 multu, 3 div, 4 divu, 5 mfhi, 6 mflo, 7 mthi, 8 mtlo.
REQ-008 d1  input  32  forwarded rs operand.
REQ-009 d2  input  32  forwarded rt operand.
REQ-010 busy  output  1  multi-cycle operation in progress.
REQ-011 out  output  32  read data: HI for op 5, LO for op 6, else 0.
REQ-012 hi  output  32  architectural HI register.
REQ-013 lo  output  32  architectural LO register.

Function
REQ-014 FSM states IDLE, RUN; a down-counter cnt (4 bits minimum) tracks remaining cycles.
REQ-015 IDLE + start=1 + req=0 + op in {1..4}: latch results into hi_tmp/lo_tmp, cnt <= MUL_CYCLES or DIV_CYCLES, go RUN.
REQ-016 busy = 1 exactly while state is RUN; start accepted at edge t gives busy high for cycles t+1 .. t+N, N = configured cycles.
REQ-017 RUN with cnt==1: commit hi_tmp/lo_tmp to hi/lo, go IDLE; new HI/LO visible the cycle busy falls.
REQ-018 RUN with cnt>1: cnt decrements; hi/lo unchanged.
REQ-019 mult: {hi,lo} = signed 64-bit d1*d2; multu: unsigned 64-bit product.
REQ-020 div: lo = signed quotient truncated toward zero, hi = remainder with sign of dividend; divu: unsigned quotient/remainder.
REQ-021 div with d1=0x80000000, d2=0xFFFFFFFF: lo=0x80000000, hi=0x00000000.
REQ-022 div/divu with d2=0: operation runs full DIV_CYCLES with busy, hi and lo keep prior values.
REQ-023 mthi/mtlo (op 7/8) with req=0: hi or lo <= d1 at the next edge, single cycle, no busy; accepted only in IDLE.
REQ-024 req=1: start and mthi/mtlo in the same cycle are ignored, state unchanged.
REQ-025 req=1 while RUN: no abort; operation completes and commits (issuing instruction already past E).
REQ-026 start or mthi/mtlo while RUN: ignored (stall logic prevents it); in-flight operation unaffected.
REQ-027 out is combinational from op and current hi/lo; mfhi/mflo during RUN return pre-commit values (stall logic prevents it).
REQ-028 start=1 with op outside {1..4}: ignored.

Reset
REQ-029 reset=1 at a clock edge: state <= IDLE, cnt <= 0, hi <= 0, lo <= 0, hi_tmp/lo_tmp <= 0; busy=0 next cycle.
REQ-030 reset during RUN discards the in-flight result; reset has priority over all other inputs.

Structure
REQ-031 Shared package mdu_pkg holds op encodings, state encoding, and default MUL_CYCLES/DIV_CYCLES constants; the pipeline CU uses the same op encodings.
REQ-032 One combinational sub-module mdu_arith computes 64-bit product and quotient/remainder including REQ-021/REQ-022 cases; mdu_seq owns FSM, counter, and HI/LO.

Verification
REQ-033 start op=1, d1=0xFFFFFFFD, d2=5 -> busy high 5 cycles, then hi=0xFFFFFFFF, lo=0xFFFFFFF1.
REQ-034 start op=4, d1=100, d2=7 -> busy high 10 cycles, then lo=14, hi=2; op=3 with d1=-7, d2=2 -> lo=0xFFFFFFFD, hi=0xFFFFFFFF.
REQ-035 hi=0x11, lo=0x22, start op=3, d2=0 -> busy 10 cycles, hi=0x11, lo=0x22 unchanged.
REQ-036 start op=2 with req=1 -> busy stays 0, hi/lo unchanged; op=7 d1=0xABCD with req=1 -> hi unchanged; op=7 req=0 then op=5 -> out=0xABCD.
REQ-037 start op=1, assert req on busy cycle 2 -> completes, result committed; separate run: reset on busy cycle 3 -> busy=0, hi=lo=0 next cycle.
REQ-038 start op=1 accepted, start op=4 on busy cycle 1 -> ignored; only mult result committed after 5 cycles.
